// File: rtl/mipi_ph_ecc_checker.sv
// CSI-2 packet-header ECC checker/corrector: 6-bit Hamming syndrome over 24 header bits, single-bit correction.
// Optional saturating error counters are built when MIPI_ECC_STATS_EN is defined.
module mipi_ph_ecc_checker #(
   parameter int PIPE_IN = 1,
   parameter int CNT_W   = 16
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_hdr_valid,
   output logic             O_hdr_ready,
   input  logic [31:0]      I_hdr,
   output logic             O_valid,
   input  logic             I_ready,
   output logic [23:0]      O_data,
   output logic             O_ecc_ok,
   output logic             O_corrected,
   output logic             O_err_uncorr,
   output logic [4:0]       O_err_bit,
   input  logic             I_cnt_clr,
   output logic [CNT_W-1:0] O_corr_cnt,
   output logic [CNT_W-1:0] O_uncorr_cnt
);

   // Data-bit membership of each parity bit P0..P5.
   localparam logic [23:0] M0 = 24'hF12CB7;
   localparam logic [23:0] M1 = 24'hF2555B;
   localparam logic [23:0] M2 = 24'h749A6D;
   localparam logic [23:0] M3 = 24'hB8E38E;
   localparam logic [23:0] M4 = 24'hDF03F0;
   localparam logic [23:0] M5 = 24'hEFFC00;

   function automatic logic [5:0] calc_syn(input logic [29:0] h);
      logic [23:0] d;
      d = h[23:0];
      return h[29:24] ^ {^(d & M5), ^(d & M4), ^(d & M3), ^(d & M2), ^(d & M1), ^(d & M0)};
   endfunction

   logic        s2_adv;
   logic        f_valid;
   logic [23:0] f_data;
   logic [5:0]  f_syn;
   logic        unused_bits;

   // A beat moves on a clock edge only when valid & ready are both high; a stage
   // accepts whenever it is empty or its contents leave on the same edge.
   assign s2_adv      = ~O_valid | I_ready;
   assign unused_bits = ^{I_hdr[31:30], I_cnt_clr};

   if (PIPE_IN != 0) begin : g_pipe
      logic        s1_valid;
      logic [23:0] s1_data;
      logic [5:0]  s1_syn;

      assign O_hdr_ready = ~s1_valid | s2_adv;

      always_ff @(posedge I_clk or posedge I_rst) begin
         if (I_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
         end else if (O_hdr_ready) begin
            s1_valid <= I_hdr_valid;
            if (I_hdr_valid) begin
               s1_data <= I_hdr[23:0];
               s1_syn  <= calc_syn(I_hdr[29:0]);
            end
         end
      end

      assign f_valid = s1_valid;
      assign f_data  = s1_data;
      assign f_syn   = s1_syn;
   end else begin : g_comb
      assign O_hdr_ready = s2_adv;
      assign f_valid     = I_hdr_valid;
      assign f_data      = I_hdr[23:0];
      assign f_syn       = calc_syn(I_hdr[29:0]);
   end

   logic [23:0] c_data;
   logic        c_ok;
   logic        c_corr;
   logic        c_unc;
   logic [4:0]  c_bit;

   always_comb begin
      c_data = f_data;
      c_ok   = 1'b0;
      c_corr = 1'b0;
      c_unc  = 1'b0;
      c_bit  = 5'd31;
      if (f_syn == 6'h00) begin
         c_ok = 1'b1;
      end else if ((f_syn & (f_syn - 6'd1)) == 6'h00) begin
         c_corr = 1'b1;
      end else begin
         c_unc = 1'b1;
         for (int i = 0; i < 24; i++) begin
            if (f_syn == {M5[i], M4[i], M3[i], M2[i], M1[i], M0[i]}) begin
               c_data[i] = ~f_data[i];
               c_corr    = 1'b1;
               c_unc     = 1'b0;
               c_bit     = 5'(i);
            end
         end
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_valid      <= 1'b0;
         O_data       <= '0;
         O_ecc_ok     <= 1'b0;
         O_corrected  <= 1'b0;
         O_err_uncorr <= 1'b0;
         O_err_bit    <= 5'd31;
      end else if (s2_adv) begin
         O_valid <= f_valid;
         if (f_valid) begin
            O_data       <= c_data;
            O_ecc_ok     <= c_ok;
            O_corrected  <= c_corr;
            O_err_uncorr <= c_unc;
            O_err_bit    <= c_bit;
         end
      end
   end

`ifdef MIPI_ECC_STATS_EN
   logic out_fire;
   assign out_fire = O_valid & I_ready;

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         O_corr_cnt   <= '0;
         O_uncorr_cnt <= '0;
      end else if (I_cnt_clr) begin
         O_corr_cnt   <= '0;
         O_uncorr_cnt <= '0;
      end else if (out_fire) begin
         if (O_corrected && (O_corr_cnt != {CNT_W{1'b1}}))
            O_corr_cnt <= O_corr_cnt + 1'b1;
         if (O_err_uncorr && (O_uncorr_cnt != {CNT_W{1'b1}}))
            O_uncorr_cnt <= O_uncorr_cnt + 1'b1;
      end
   end
`else
   assign O_corr_cnt   = '0;
   assign O_uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_mipi_ph_ecc_checker.sv
// Directed bench for mipi_ph_ecc_checker: hand-computed headers, stall burst, mid-stream reset and counters.
module tb_mipi_ph_ecc_checker;

   localparam int PIPE_IN = 1;
`ifdef MIPI_ECC_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic             I_clk;
   logic             I_rst;
   logic             I_hdr_valid;
   logic             O_hdr_ready;
   logic [31:0]      I_hdr;
   logic             O_valid;
   logic             I_ready;
   logic [23:0]      O_data;
   logic             O_ecc_ok;
   logic             O_corrected;
   logic             O_err_uncorr;
   logic [4:0]       O_err_bit;
   logic             I_cnt_clr;
   logic [CNT_W-1:0] O_corr_cnt;
   logic [CNT_W-1:0] O_uncorr_cnt;

   mipi_ph_ecc_checker #(.PIPE_IN(PIPE_IN), .CNT_W(CNT_W)) dut (
      .I_clk(I_clk), .I_rst(I_rst),
      .I_hdr_valid(I_hdr_valid), .O_hdr_ready(O_hdr_ready), .I_hdr(I_hdr),
      .O_valid(O_valid), .I_ready(I_ready), .O_data(O_data),
      .O_ecc_ok(O_ecc_ok), .O_corrected(O_corrected), .O_err_uncorr(O_err_uncorr),
      .O_err_bit(O_err_bit), .I_cnt_clr(I_cnt_clr),
      .O_corr_cnt(O_corr_cnt), .O_uncorr_cnt(O_uncorr_cnt)
   );

   // clock / reset
   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   // expected result word: {ok, corrected, uncorr, err_bit, data}
   function automatic logic [31:0] ew(input logic ok, input logic cr, input logic un,
                                      input logic [4:0] b, input logic [23:0] d);
      return {ok, cr, un, b, d};
   endfunction

   logic [31:0] hdr_tab[11];
   logic [31:0] exp_tab[11];

   initial begin
      hdr_tab[0]  = 32'h00000000; exp_tab[0]  = ew(1, 0, 0, 31, 24'h000000);
      hdr_tab[1]  = 32'h3B800000; exp_tab[1]  = ew(1, 0, 0, 31, 24'h800000);
      hdr_tab[2]  = 32'h00000001; exp_tab[2]  = ew(0, 1, 0,  0, 24'h000000);
      hdr_tab[3]  = 32'h01000000; exp_tab[3]  = ew(0, 1, 0, 31, 24'h000000);
      hdr_tab[4]  = 32'h00000003; exp_tab[4]  = ew(0, 0, 1, 31, 24'h000003);
      hdr_tab[5]  = 32'hC0000000; exp_tab[5]  = ew(1, 0, 0, 31, 24'h000000);
      hdr_tab[6]  = 32'h00800000; exp_tab[6]  = ew(0, 1, 0, 23, 24'h000000);
      hdr_tab[7]  = 32'h07000021; exp_tab[7]  = ew(0, 1, 0,  5, 24'h000001);
      hdr_tab[8]  = 32'h07000001; exp_tab[8]  = ew(1, 0, 0, 31, 24'h000001);
      hdr_tab[9]  = 32'h00001000; exp_tab[9]  = ew(0, 1, 0, 12, 24'h000000);
      hdr_tab[10] = 32'h20000000; exp_tab[10] = ew(0, 1, 0, 31, 24'h000000);
   end

   // scoreboard: every valid output is compared with the queue head, popped on transfer
   always @(negedge I_clk) begin
      if (!I_rst && O_valid) begin
         if (exp_q.size() == 0) begin
            check("no_exp", {31'b0, O_valid}, 32'h0);
         end else begin
            check("out", {O_ecc_ok, O_corrected, O_err_uncorr, O_err_bit, O_data}, exp_q[0]);
            if (I_ready) void'(exp_q.pop_front());
         end
      end
   end

   // driver: called at posedge+1, returns at posedge+1 after the accepting edge
   task automatic send(input int idx);
      int n;
      n = 0;
      I_hdr_valid = 1'b1;
      I_hdr       = hdr_tab[idx];
      exp_q.push_back(exp_tab[idx]);
      #1;
      while (!O_hdr_ready && n < 50) begin
         @(posedge I_clk); #2;
         n++;
      end
      if (n >= 50) check("ready_timeout", {31'b0, O_hdr_ready}, 32'h1);
      @(posedge I_clk); #1;
      I_hdr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge I_clk); #1;
         n++;
      end
      check("drain", exp_q.size(), 32'h0);
   endtask

   task automatic do_reset();
      I_rst = 1'b1;
      repeat (2) @(posedge I_clk);
      #1;
      I_rst = 1'b0;
   endtask

   initial begin
      I_rst = 1'b0; I_hdr_valid = 1'b0; I_hdr = '0; I_ready = 1'b1; I_cnt_clr = 1'b0;
      #1;
      I_rst = 1'b1;
      repeat (2) @(posedge I_clk);
      #1;
      check("rst_valid", {31'b0, O_valid}, 32'h0);
      check("rst_word", {O_ecc_ok, O_corrected, O_err_uncorr, O_err_bit, O_data}, 32'h1F000000);
      check("rst_ready", {31'b0, O_hdr_ready}, 32'h1);
      check("rst_cnt", {32'(O_corr_cnt), 32'(O_uncorr_cnt)} == 64'h0 ? 32'h0 : 32'h1, 32'h0);
      I_rst = 1'b0;
      @(posedge I_clk); #1;

      // latency of a single header
      send(0);
      for (int i = 0; i < PIPE_IN; i++) begin
         check("lat_early", {31'b0, O_valid}, 32'h0);
         @(posedge I_clk); #1;
      end
      check("lat_valid", {31'b0, O_valid}, 32'h1);
      drain();

      // isolated directed vectors
      for (int i = 1; i < 11; i++) begin
         send(i);
         drain();
      end

      // back-to-back burst with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 8; i++) send(i);
         end
         begin
            repeat (3) @(posedge I_clk);
            #1 I_ready = 1'b0;
            repeat (3) @(posedge I_clk);
            #1 I_ready = 1'b1;
         end
      join
      drain();

`ifdef MIPI_ECC_STATS_EN
      I_cnt_clr = 1'b1;
      @(posedge I_clk); #1;
      I_cnt_clr = 1'b0;
      check("clr_corr", 32'(O_corr_cnt), 32'h0);
      for (int i = 0; i < 5; i++) send(2);
      send(4);
      drain();
      @(posedge I_clk); #1;
      check("sat_corr", 32'(O_corr_cnt), 32'h3);
      check("cnt_uncorr", 32'(O_uncorr_cnt), 32'h1);
      // clear coinciding with a corrected header leaving the output
      I_ready = 1'b0;
      send(2);
      for (int n = 0; n < 20 && !O_valid; n++) begin
         @(posedge I_clk); #1;
      end
      check("stall_valid", {31'b0, O_valid}, 32'h1);
      I_ready   = 1'b1;
      I_cnt_clr = 1'b1;
      @(posedge I_clk); #1;
      I_cnt_clr = 1'b0;
      check("clr_wins", 32'(O_corr_cnt), 32'h0);
      drain();
`else
      check("cnt_tied_corr", 32'(O_corr_cnt), 32'h0);
      check("cnt_tied_uncorr", 32'(O_uncorr_cnt), 32'h0);
`endif

      // reset with two headers in flight
      send(2);
      send(3);
      I_rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'b0, O_valid}, 32'h0);
      check("mid_rst_word", {O_ecc_ok, O_corrected, O_err_uncorr, O_err_bit, O_data}, 32'h1F000000);
      check("mid_rst_cnt", 32'(O_corr_cnt), 32'h0);
      exp_q.delete();
      @(posedge I_clk); #1;
      I_rst = 1'b0;
      @(posedge I_clk); #1;
      check("post_rst_valid", {31'b0, O_valid}, 32'h0);
      send(7);
      drain();
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
